// File: rtl/frame_buf_arbiter.sv
// frame_buf_arbiter: round-robin SDRAM burst arbiter for a multi-buffered camera-to-LCD frame store
module frame_buf_arbiter #(
    parameter int          BURST_LEN     = 160,
    parameter int          FRAME_WORDS   = 76800,
    parameter int          NUM_BUF       = 3,
    parameter logic [21:0] BUF_STRIDE    = 22'h020000,
    parameter int          RD_FIFO_DEPTH = 512,
    parameter int          LVL_W         = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [LVL_W-1:0] wr_level,
    input  logic [LVL_W-1:0] rd_level,
    input  logic             wr_frame_start,
    input  logic             rd_frame_start,
    input  logic             freeze,
    output logic             sdram_wr_req,
    input  logic             sdram_wr_ack,
    output logic             sdram_rd_req,
    input  logic             sdram_rd_ack,
    output logic [21:0]      sys_wraddr,
    output logic [21:0]      sys_rdaddr,
    output logic [8:0]       sdwr_byte,
    output logic [8:0]       sdrd_byte,
    output logic [1:0]       wr_buf_idx,
    output logic [1:0]       rd_buf_idx,
    output logic             frame_pub,
    output logic             wr_drop
);
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_BUSY, RD_REQ, RD_BUSY} state_t;
    localparam logic [21:0] FW = 22'(FRAME_WORDS);
    state_t      state_q, state_d;
    logic [21:0] wr_off_q, wr_off_d, rd_off_q, rd_off_d;
    logic [1:0]  wr_buf_q, wr_buf_d, rd_buf_q, rd_buf_d, latest_q, latest_d, nxt_buf;
    logic        rd_valid_q, rd_valid_d, wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d;
    logic        rr_rd_q, rr_rd_d, pub_q, pub_d, drop_q, drop_d;
    logic [21:0] wr_addr, rd_addr;
    logic [8:0]  wr_len, rd_len;
    logic        wr_side, rd_side, wr_start, rd_start, wr_go, rd_go;

    function automatic logic [8:0] burst_len(input logic [21:0] off, input logic [7:0] col);
        logic [21:0] rem;
        logic [8:0]  l;
        rem = FW - off;
        l = 9'(BURST_LEN);
        l = (9'd256 - {1'b0, col}) < l ? 9'd256 - {1'b0, col} : l;
        return rem < {13'd0, l} ? rem[8:0] : l;
    endfunction

    assign wr_addr  = {20'd0, wr_buf_q} * BUF_STRIDE + wr_off_q;
    assign rd_addr  = {20'd0, rd_buf_q} * BUF_STRIDE + rd_off_q;
    assign wr_len   = burst_len(wr_off_q, wr_addr[7:0]);
    assign rd_len   = burst_len(rd_off_q, rd_addr[7:0]);
    assign wr_side  = state_q inside {WR_REQ, WR_BUSY};
    assign rd_side  = state_q inside {RD_REQ, RD_BUSY};
    assign wr_start = !wr_side && (wr_frame_start || wr_pend_q);
    assign rd_start = !rd_side && (rd_frame_start || rd_pend_q);
    assign wr_go    = wr_off_q != FW && 32'(wr_len) <= 32'(wr_level) && !wr_start;
    assign rd_go    = rd_valid_q && rd_off_q != FW && 32'(rd_len) + 32'(rd_level) <= 32'(RD_FIFO_DEPTH) && !rd_start;

    always_comb begin
        state_d    = state_q;
        wr_off_d   = wr_off_q;
        rd_off_d   = rd_off_q;
        wr_buf_d   = wr_buf_q;
        rd_buf_d   = rd_buf_q;
        latest_d   = latest_q;
        rd_valid_d = rd_valid_q;
        rr_rd_d    = rr_rd_q;
        pub_d      = 1'b0;
        drop_d     = 1'b0;
        nxt_buf    = wr_buf_q;
        wr_pend_d  = wr_pend_q | (wr_side & wr_frame_start);
        rd_pend_d  = rd_pend_q | (rd_side & rd_frame_start);
        case (state_q)
            IDLE: begin
                state_d = (wr_go && (!rd_go || !rr_rd_q)) ? WR_REQ : rd_go ? RD_REQ : IDLE;
                rr_rd_d = state_d == WR_REQ ? 1'b1 : state_d == RD_REQ ? 1'b0 : rr_rd_q;
            end
            WR_REQ:  state_d = sdram_wr_ack ? WR_BUSY : WR_REQ;
            RD_REQ:  state_d = sdram_rd_ack ? RD_BUSY : RD_REQ;
            WR_BUSY: if (!sdram_wr_ack) begin
                state_d  = IDLE;
                wr_off_d = wr_off_q + 22'(wr_len);
            end
            RD_BUSY: if (!sdram_rd_ack) begin
                state_d  = IDLE;
                rd_off_d = rd_off_q + 22'(rd_len);
            end
            default: state_d = IDLE;
        endcase
        if (state_q == WR_BUSY && !sdram_wr_ack && wr_off_d == FW && !freeze) begin
            latest_d   = wr_buf_q;
            rd_valid_d = 1'b1;
            pub_d      = 1'b1;
        end
        if (rd_start) begin
            rd_pend_d = 1'b0;
            rd_buf_d  = rd_valid_d ? latest_d : rd_buf_q;
            rd_off_d  = rd_valid_d ? 22'd0 : rd_off_q;
        end
        for (int i = NUM_BUF - 1; i >= 0; i--)
            if (2'(i) != rd_buf_d && (NUM_BUF < 3 || 2'(i) != latest_d)) nxt_buf = 2'(i);
        if (wr_start) begin
            wr_pend_d = 1'b0;
            wr_off_d  = 22'd0;
            drop_d    = wr_off_q != FW && wr_off_q != 22'd0;
            wr_buf_d  = drop_d ? wr_buf_q : nxt_buf;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_off_q   <= 22'd0;
            rd_off_q   <= 22'd0;
            wr_buf_q   <= 2'd0;
            rd_buf_q   <= 2'd0;
            latest_q   <= 2'd0;
            rd_valid_q <= 1'b0;
            wr_pend_q  <= 1'b0;
            rd_pend_q  <= 1'b0;
            rr_rd_q    <= 1'b0;
            pub_q      <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_off_q   <= wr_off_d;
            rd_off_q   <= rd_off_d;
            wr_buf_q   <= wr_buf_d;
            rd_buf_q   <= rd_buf_d;
            latest_q   <= latest_d;
            rd_valid_q <= rd_valid_d;
            wr_pend_q  <= wr_pend_d;
            rd_pend_q  <= rd_pend_d;
            rr_rd_q    <= rr_rd_d;
            pub_q      <= pub_d;
            drop_q     <= drop_d;
        end
    end

    assign sdram_wr_req = state_q == WR_REQ;
    assign sdram_rd_req = state_q == RD_REQ;
    assign sys_wraddr   = wr_addr;
    assign sys_rdaddr   = rd_addr;
    assign sdwr_byte    = wr_len;
    assign sdrd_byte    = rd_len;
    assign wr_buf_idx   = wr_buf_q;
    assign rd_buf_idx   = rd_buf_q;
    assign frame_pub    = pub_q;
    assign wr_drop      = drop_q;
endmodule
